// File: rtl/thor2024_rt_scoreboard.sv
// thor2024_rt_scoreboard
//   Tracks which architectural registers have an in-flight write. An issued
//   instruction marks its target register busy and records its tag there.
//   A writeback clears the busy flag only when its tag matches the recorded
//   tag, so that only the youngest writer of a register can clear it. Issue
//   is held while any source register is still pending. A writeback in the
//   same cycle bypasses straight into that pending check.
//   Register 0 means "no target" and is never tracked.
//
// Ports
//   clk, rst                 core clock, asynchronous active-high reset
//   flush                    clears all busy flags (the tags are kept)
//   iss_v/rt/tag/ra/rb/rc    issue slot: valid, target, tag, three sources
//   stall                    combinational: a source register is pending
//   iss_ack                  combinational: issue accepted this cycle
//   wb_v/rt/tag              writeback bus
//   busy_vec                 registered busy flags
//   busy_cnt                 registered number of busy registers

// One tracked register: its busy flag and the tag of its youngest writer.
module thor2024_rt_scoreboard_reg #(
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            set,       // accepted issue targets this register
  input  logic [TAGW-1:0] set_tag,
  input  logic            wb_hit,    // writeback addresses this register
  input  logic [TAGW-1:0] wb_tag,
  output logic            busy,
  output logic            live,      // writeback clears this register now
  output logic            busy_nxt
);
  logic [TAGW-1:0] tag;

  assign live = wb_hit & busy & (wb_tag == tag);

  // Priority: flush, then issue, then writeback. An issue in the same cycle
  // beats the writeback, which is then treated as stale.
  always_comb begin
    busy_nxt = busy;
    if (flush)     busy_nxt = 1'b0;
    else if (set)  busy_nxt = 1'b1;
    else if (live) busy_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      tag  <= '0;
    end else begin
      busy <= busy_nxt;
      if (set && !flush) tag <= set_tag;
    end
  end
endmodule

module thor2024_rt_scoreboard #(
  parameter  int NREG = 64,
  parameter  int TAGW = 4,
  localparam int RW   = $clog2(NREG),
  localparam int CW   = $clog2(NREG + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            iss_v,
  input  logic [RW-1:0]   iss_rt,
  input  logic [TAGW-1:0] iss_tag,
  input  logic [RW-1:0]   iss_ra,
  input  logic [RW-1:0]   iss_rb,
  input  logic [RW-1:0]   iss_rc,
  output logic            stall,
  output logic            iss_ack,
  input  logic            wb_v,
  input  logic [RW-1:0]   wb_rt,
  input  logic [TAGW-1:0] wb_tag,
  output logic [NREG-1:0] busy_vec,
  output logic [CW-1:0]   busy_cnt
);
  logic [NREG-1:0] busy, live, busy_nxt, pend;
  logic [CW-1:0]   cnt_nxt;

  // Register 0 is hard-wired idle, so it can never stall or be counted.
  assign busy[0]     = 1'b0;
  assign live[0]     = 1'b0;
  assign busy_nxt[0] = 1'b0;

  for (genvar g = 1; g < NREG; g++) begin : g_reg
    thor2024_rt_scoreboard_reg #(.TAGW(TAGW)) u_reg (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .set      (iss_ack && iss_rt == RW'(g)),
      .set_tag  (iss_tag),
      .wb_hit   (wb_v && wb_rt == RW'(g)),
      .wb_tag   (wb_tag),
      .busy     (busy[g]),
      .live     (live[g]),
      .busy_nxt (busy_nxt[g])
    );
  end

  // A matching writeback in this cycle already supplies the value.
  assign pend    = busy & ~live;
  assign stall   = iss_v & (pend[iss_ra] | pend[iss_rb] | pend[iss_rc]);
  assign iss_ack = iss_v & ~stall & ~flush;

  // The count is taken from the next state, so it lines up with busy_vec.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= '0;
    else     busy_cnt <= cnt_nxt;
  end

  assign busy_vec = busy;
endmodule

// File: tb/tb_thor2024_rt_scoreboard.sv
module tb_thor2024_rt_scoreboard;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic        iss_v = 1'b0, wb_v = 1'b0;
  logic [5:0]  iss_rt = '0, iss_ra = '0, iss_rb = '0, iss_rc = '0, wb_rt = '0;
  logic [3:0]  iss_tag = '0, wb_tag = '0;
  logic        stall, iss_ack;
  logic [63:0] busy_vec;
  logic [6:0]  busy_cnt;

  int checks = 0, errors = 0;

  thor2024_rt_scoreboard #(.NREG(64), .TAGW(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_v(iss_v), .iss_rt(iss_rt), .iss_tag(iss_tag),
    .iss_ra(iss_ra), .iss_rb(iss_rb), .iss_rc(iss_rc),
    .stall(stall), .iss_ack(iss_ack),
    .wb_v(wb_v), .wb_rt(wb_rt), .wb_tag(wb_tag),
    .busy_vec(busy_vec), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic fl, iv; logic [5:0] rt; logic [3:0] tg; logic [5:0] ra, rb, rc;
    logic wv; logic [5:0] wrt; logic [3:0] wtg;
    logic xs, xa; logic [63:0] xv; logic [6:0] xc;
  } vec_t;
  typedef struct { logic [63:0] v; logic [6:0] c; } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];

  function automatic vec_t mk(logic fl, logic iv, int rt, int tg, int ra, int rb, int rc,
                              logic wv, int wrt, int wtg, logic xs, logic xa,
                              logic [63:0] xv, int xc);
    vec_t t;
    t.fl = fl; t.iv = iv; t.rt = 6'(rt); t.tg = 4'(tg);
    t.ra = 6'(ra); t.rb = 6'(rb); t.rc = 6'(rc);
    t.wv = wv; t.wrt = 6'(wrt); t.wtg = 4'(wtg);
    t.xs = xs; t.xa = xa; t.xv = xv; t.xc = 7'(xc);
    return t;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one cycle, check the combinational outputs before the edge, and
  // queue the expected registered state for comparison after the edge.
  task automatic apply(vec_t t, int idx);
    exp_t e;
    @(negedge clk);
    flush = t.fl; iss_v = t.iv; iss_rt = t.rt; iss_tag = t.tg;
    iss_ra = t.ra; iss_rb = t.rb; iss_rc = t.rc;
    wb_v = t.wv; wb_rt = t.wrt; wb_tag = t.wtg;
    #1;
    chk($sformatf("v%0d stall", idx), 64'(stall), 64'(t.xs));
    chk($sformatf("v%0d iss_ack", idx), 64'(iss_ack), 64'(t.xa));
    sbq.push_back('{v: t.xv, c: t.xc});
    @(posedge clk); #1;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL v%0d scoreboard empty", idx);
    end else begin
      e = sbq.pop_front();
      chk($sformatf("v%0d busy_vec", idx), busy_vec, e.v);
      chk($sformatf("v%0d busy_cnt", idx), 64'(busy_cnt), 64'(e.c));
    end
  endtask

  initial begin
    logic [63:0] m;
    //            fl iv rt tg ra rb rc wv wrt wtg xs xa  busy_vec     cnt
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0,   0)); // idle
    tbl.push_back(mk(0, 1, 5, 3, 0, 0, 0, 0, 0, 0, 0, 1, 64'h20,  1)); // rt5 t3
    tbl.push_back(mk(0, 1, 0, 0, 5, 0, 0, 0, 0, 0, 1, 0, 64'h20,  1)); // ra5 stall
    tbl.push_back(mk(0, 1, 0, 0, 5, 0, 0, 1, 5, 3, 0, 1, 64'h0,   0)); // bypass
    tbl.push_back(mk(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 64'h80,  1)); // WAW
    tbl.push_back(mk(0, 1, 7, 2, 0, 0, 0, 0, 0, 0, 0, 1, 64'h80,  1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 0, 0, 64'h80,  1)); // older wb stale
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 2, 0, 0, 64'h0,   0)); // youngest clears
    tbl.push_back(mk(0, 1, 9, 2, 0, 0, 0, 0, 0, 0, 0, 1, 64'h200, 1));
    tbl.push_back(mk(0, 1, 9, 4, 0, 0, 0, 1, 9, 2, 0, 1, 64'h200, 1)); // issue wins
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 2, 0, 0, 64'h200, 1)); // old tag stale
    tbl.push_back(mk(0, 1, 0, 0, 9, 0, 0, 1, 9, 4, 0, 1, 64'h0,   0)); // new tag clears
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0,   0)); // rt0 untracked
    tbl.push_back(mk(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 64'h2,   1));
    tbl.push_back(mk(0, 1, 2, 6, 0, 0, 0, 1, 1, 5, 0, 1, 64'h4,   1)); // diff regs
    tbl.push_back(mk(0, 1, 3, 7, 0, 0, 2, 0, 0, 0, 1, 0, 64'h4,   1)); // rc pending
    tbl.push_back(mk(0, 1, 3, 7, 0, 0, 0, 0, 0, 0, 0, 1, 64'hC,   2));
    tbl.push_back(mk(0, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 1, 64'hE,   3));
    tbl.push_back(mk(1, 1, 4, 9, 0, 0, 0, 1, 1, 8, 0, 0, 64'h0,   0)); // flush
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0, 64'h0,   0)); // wb after flush
    tbl.push_back(mk(0, 1,10, 1, 0, 0, 0, 0, 0, 0, 0, 1, 64'h400, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0,10, 0, 0, 0, 0, 1, 0, 64'h400, 1)); // rb pending
    tbl.push_back(mk(0, 0, 0, 0, 0,10, 0, 0, 0, 0, 0, 0, 64'h400, 1)); // no iss_v

    // Reset state: combinational outputs quiet, registers clear.
    #1;
    chk("rst stall", 64'(stall), 64'h0);
    chk("rst iss_ack", 64'(iss_ack), 64'h0);
    chk("rst busy_vec", busy_vec, 64'h0);
    chk("rst busy_cnt", 64'(busy_cnt), 64'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Asynchronous reset mid-operation clears immediately, before any edge.
    @(negedge clk);
    iss_v = 1'b1; iss_ra = 6'd10; iss_rt = 6'd0; iss_rb = 6'd0; iss_rc = 6'd0;
    wb_v = 1'b0; flush = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst busy_vec", busy_vec, 64'h0);
    chk("arst busy_cnt", 64'(busy_cnt), 64'h0);
    chk("arst stall", 64'(stall), 64'h0);
    @(negedge clk);
    rst = 1'b0; iss_v = 1'b0; iss_ra = 6'd0;

    // Fill every trackable register, then drain them: busy_cnt peaks at 63.
    m = '0;
    for (int r = 1; r < 64; r++) begin
      m[r] = 1'b1;
      apply(mk(0, 1, r, r % 16, 0, 0, 0, 0, 0, 0, 0, 1, m, r), 100 + r);
    end
    apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, m, 63), 164); // rt0 at full
    for (int r = 1; r < 64; r++) begin
      m[r] = 1'b0;
      apply(mk(0, 0, 0, 0, 0, 0, 0, 1, r, r % 16, 0, 0, m, 63 - r), 200 + r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
